// File: rtl/eeprom_pkg.sv
// Shared types and timing constants for the 28C16 write controller and its bench model.
// Holds the controller state encoding, pin-strobe bundle and default timing derived from device data.
package eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_POLL_RD  = 3'd4,
    ST_POLL_GAP = 3'd5,
    ST_DONE     = 3'd6,
    ST_FAIL     = 3'd7
  } state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } strobes_t;

  localparam int CLK_PERIOD_NS = 20;
  localparam int EE_TACC_NS    = 150;
  localparam int EE_TWC_NS     = 1_000_000;

  function automatic int ns_to_cycles(input int ns);
    return (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
  endfunction

  // Poll budget is twice the worst-case internal write cycle.
  localparam int DEF_ADDR_W          = 8;
  localparam int DEF_SETUP_CYCLES    = 1;
  localparam int DEF_WE_PULSE_CYCLES = 2;
  localparam int DEF_READ_CYCLES     = ns_to_cycles(EE_TACC_NS);
  localparam int DEF_POLL_TIMEOUT    = 2 * ns_to_cycles(EE_TWC_NS);

  localparam strobes_t STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

  function automatic strobes_t strobes_for(input state_e s);
    strobes_t r;
    r = STROBES_IDLE;
    case (s)
      ST_SETUP, ST_HOLD: begin
        r.ce_n  = 1'b0;
        r.dq_oe = 1'b1;
      end
      ST_PULSE: begin
        r.ce_n  = 1'b0;
        r.we_n  = 1'b0;
        r.dq_oe = 1'b1;
      end
      ST_POLL_RD: begin
        r.ce_n = 1'b0;
        r.oe_n = 1'b0;
      end
      ST_POLL_GAP: r.ce_n = 1'b0;
      default: r = STROBES_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; times the setup, WE pulse and read-access phases.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/eeprom_writer.sv
// Single-byte write controller for a 28C16-class EEPROM with DATA-polling completion detect.
// Define EEPROM_WRITER_VERIFY_EN to add a full-byte read-back compare after the bit-7 poll succeeds.
module eeprom_writer import eeprom_pkg::*; #(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int WE_PULSE_CYCLES = DEF_WE_PULSE_CYCLES,
  parameter int READ_CYCLES     = DEF_READ_CYCLES,
  parameter int POLL_TIMEOUT    = DEF_POLL_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_ee_addr,
  output logic [7:0]        o_ee_dq_out,
  output logic              o_ee_dq_oe,
  input  logic [7:0]        i_ee_dq_in,
  output logic              o_ee_ce_n,
  output logic              o_ee_oe_n,
  output logic              o_ee_we_n
);

  localparam int TMR_MAX_A = (SETUP_CYCLES > WE_PULSE_CYCLES) ? SETUP_CYCLES : WE_PULSE_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > READ_CYCLES) ? TMR_MAX_A : READ_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int CNT_W     = $clog2(POLL_TIMEOUT + 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_data;
  logic                r_wr_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  strobes_t            r_strobes;
  logic [CNT_W-1:0]    r_poll_cnt;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_tmr_zero;
  logic                w_accept;
  logic                w_in_poll;
  logic                w_poll_last;
  logic                w_bit7_ok;

  assign w_accept    = i_wr_valid & r_wr_ready;
  assign w_in_poll   = (r_state == ST_POLL_RD) || (r_state == ST_POLL_GAP);
  assign w_poll_last = (r_poll_cnt == CNT_W'(POLL_TIMEOUT - 2));
  assign w_bit7_ok   = (i_ee_dq_in[7] == r_data[7]);

`ifdef EEPROM_WRITER_VERIFY_EN
  logic r_verify;
  logic w_verify_set;
  logic w_byte_ok;

  assign w_byte_ok = (i_ee_dq_in == r_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_verify <= 1'b0;
    end else if (r_state == ST_HOLD) begin
      r_verify <= 1'b0;
    end else if (w_verify_set) begin
      r_verify <= 1'b1;
    end
  end
`else
  logic w_unused_dq;
  assign w_unused_dq = ^i_ee_dq_in[6:0];
`endif

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // Every phase timer is loaded with N-1 on the edge that enters the phase, so it lasts N clocks.
  always_comb begin
    w_next_state = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
`ifdef EEPROM_WRITER_VERIFY_EN
    w_verify_set = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_SETUP;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(SETUP_CYCLES - 1);
        end
      end
      ST_SETUP: begin
        if (w_tmr_zero) begin
          w_next_state = ST_PULSE;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(WE_PULSE_CYCLES - 1);
        end
      end
      ST_PULSE: begin
        if (w_tmr_zero) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_next_state = ST_POLL_RD;
        w_tmr_load   = 1'b1;
        w_tmr_val    = TMR_W'(READ_CYCLES - 1);
      end
      ST_POLL_RD: begin
        if (w_tmr_zero) begin
`ifdef EEPROM_WRITER_VERIFY_EN
          if (r_verify) begin
            w_next_state = w_byte_ok ? ST_DONE : ST_FAIL;
          end else if (w_bit7_ok) begin
            w_next_state = ST_POLL_GAP;
            w_verify_set = 1'b1;
          end else
`else
          if (w_bit7_ok) begin
            w_next_state = ST_DONE;
          end else
`endif
          if (w_poll_last) begin
            w_next_state = ST_FAIL;
          end else begin
            w_next_state = ST_POLL_GAP;
          end
        end else if (w_poll_last) begin
          w_next_state = ST_FAIL;
        end
      end
      ST_POLL_GAP: begin
        if (w_poll_last) begin
          w_next_state = ST_FAIL;
        end else begin
          w_next_state = ST_POLL_RD;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(READ_CYCLES - 1);
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      ST_FAIL:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins change exactly on the state edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_strobes  <= STROBES_IDLE;
    end else begin
      r_state    <= w_next_state;
      r_wr_ready <= (w_next_state == ST_IDLE);
      r_busy     <= w_next_state inside {ST_SETUP, ST_PULSE, ST_HOLD, ST_POLL_RD, ST_POLL_GAP};
      r_done     <= (w_next_state == ST_DONE);
      r_err      <= (w_next_state == ST_FAIL);
      r_strobes  <= strobes_for(w_next_state);
      if (w_accept) begin
        r_addr <= i_wr_addr;
        r_data <= i_wr_data;
      end
    end
  end

  // Poll budget counts from the first read after HOLD and stops once the limit is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_poll_cnt <= '0;
    end else if (r_state == ST_HOLD) begin
      r_poll_cnt <= '0;
    end else if (w_in_poll && (r_poll_cnt != CNT_W'(POLL_TIMEOUT - 1))) begin
      r_poll_cnt <= r_poll_cnt + CNT_W'(1);
    end
  end

  assign o_wr_ready  = r_wr_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_ee_addr   = r_addr;
  assign o_ee_dq_out = r_data;
  assign o_ee_dq_oe  = r_strobes.dq_oe;
  assign o_ee_ce_n   = r_strobes.ce_n;
  assign o_ee_oe_n   = r_strobes.oe_n;
  assign o_ee_we_n   = r_strobes.we_n;

  a_no_we_oe_overlap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(!r_strobes.we_n && !r_strobes.oe_n));
  a_no_drive_while_read: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(r_strobes.dq_oe && !r_strobes.oe_n));

endmodule
